// File: rtl/data_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_bridge
// Purpose  : Turns M-stage load/store requests into single-outstanding
//            req/ack bus transactions, stalls the pipeline until the bus
//            responds, and flags misaligned accesses and bus timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_bridge #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,          // asynchronous, active low
    input  logic              memwriteM,
    input  logic              memreadM,
    input  logic [31:0]       aluoutM,
    input  logic [31:0]       writedataM,
    output logic [31:0]       readdataM,
    output logic              stallM,
    output logic              adelM,
    output logic              adesM,
    output logic              buserrM,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    // Last counter value before a WAIT without ack is abandoned
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_cnt;
    logic [31:0]       r_readdata;
    logic              r_buserr;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    logic              w_act;
    logic              w_mis;
    logic              w_issue;
    logic              w_tmo;

    // A store wins when both strobes are high; only word accesses exist
    assign w_act   = memreadM | memwriteM;
    assign w_mis   = w_act & (aluoutM[1:0] != 2'b00);
    assign w_issue = (r_state == S_IDLE) & w_act & ~w_mis;
    assign w_tmo   = (r_cnt == c_TO_LAST);

    assign readdataM = r_readdata;
    assign buserrM   = r_buserr;
    assign bus_req   = r_req;
    assign bus_we    = r_we;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and combinational pipeline outputs; alignment flags only in IDLE
    always_comb begin
        w_next = r_state;
        stallM = 1'b0;
        adelM  = 1'b0;
        adesM  = 1'b0;
        case (r_state)
            S_IDLE: begin
                adelM  = w_mis & ~memwriteM;
                adesM  = w_mis & memwriteM;
                stallM = w_act & ~w_mis;
                if (w_act && !w_mis) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                stallM = 1'b1;
                if (bus_ack || w_tmo) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Bus request launch, response capture and timeout tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_readdata <= '0;
            r_cnt      <= '0;
            r_buserr   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_req   <= 1'b1;
                        r_we    <= memwriteM;
                        r_addr  <= {aluoutM[ADDR_W-1:2], 2'b00};
                        r_wdata <= writedataM;
                        r_cnt   <= '0;
                    end
                end
                S_WAIT: begin
                    if (bus_ack) begin
                        r_req    <= 1'b0;
                        r_buserr <= 1'b0;
                        if (!r_we) begin
                            r_readdata <= bus_rdata;
                        end
                    end else if (w_tmo) begin
                        r_req      <= 1'b0;
                        r_readdata <= '0;
                        r_buserr   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_buserr <= 1'b0;
                end
                default: begin
                    r_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_data_mem_bridge
// Purpose  : Self-checking bench for data_mem_bridge: directed vector table,
//            randomized transactions against a transaction-level model,
//            timeout and reset-abandon sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        memwriteM, memreadM;
    logic [31:0] aluoutM, writedataM;
    logic [31:0] readdataM;
    logic        stallM, adelM, adesM, buserrM;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    // Second instance with a short timeout
    logic        t_wr, t_rd;
    logic [31:0] t_addr, t_wdata;
    logic [31:0] t_readdata;
    logic        t_stall, t_adel, t_ades, t_buserr;
    logic        t_req, t_we;
    logic [31:0] t_baddr, t_bwdata;
    logic        t_ack;
    logic [31:0] t_rdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_rd;   // model: value the pipeline currently sees on readdataM

    always #5 clk = ~clk;

    data_mem_bridge #(.ADDR_W(32), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .memwriteM(memwriteM), .memreadM(memreadM),
        .aluoutM(aluoutM), .writedataM(writedataM),
        .readdataM(readdataM), .stallM(stallM),
        .adelM(adelM), .adesM(adesM), .buserrM(buserrM),
        .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    data_mem_bridge #(.ADDR_W(32), .TIMEOUT(4)) dut_t (
        .clk(clk), .rst(rst),
        .memwriteM(t_wr), .memreadM(t_rd),
        .aluoutM(t_addr), .writedataM(t_wdata),
        .readdataM(t_readdata), .stallM(t_stall),
        .adelM(t_adel), .adesM(t_ades), .buserrM(t_buserr),
        .bus_req(t_req), .bus_we(t_we),
        .bus_addr(t_baddr), .bus_wdata(t_bwdata),
        .bus_ack(t_ack), .bus_rdata(t_rdata)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;      // WAIT cycles until ack (ack on the last one)
        logic [31:0] rdata;
        logic        adel;
        logic        ades;
        int          stall;    // expected stalled cycles
        logic [31:0] rdexp;    // readdataM in DONE (or after a misaligned request)
        logic        we;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one M-stage request and respond on the bus after dly WAIT cycles
    task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int dly, input logic [31:0] rdata,
                          input logic exp_adel, input logic exp_ades, input int exp_stall,
                          input logic [31:0] exp_rd, input logic exp_we);
        int st;
        logic [31:0] exp_addr;
        exp_addr = addr & 32'hFFFF_FFFC;
        @(posedge clk); #1;
        memreadM = rd; memwriteM = wr; aluoutM = addr; writedataM = wdata;
        @(negedge clk);
        chk("adelM", 32'(adelM), 32'(exp_adel));
        chk("adesM", 32'(adesM), 32'(exp_ades));
        st = int'(stallM);
        if (exp_adel || exp_ades) begin
            chk("stall_misaligned", 32'(st), 32'(exp_stall));
            @(posedge clk); #1;
            chk("req_misaligned", 32'(bus_req), 32'd0);
            chk("readdata_hold", readdataM, exp_rd);
            memreadM = 1'b0; memwriteM = 1'b0;
            return;
        end
        @(posedge clk); #1;
        for (int i = 1; i <= dly; i++) begin
            if (i == dly) begin
                bus_ack = 1'b1; bus_rdata = rdata;
            end
            @(negedge clk);
            st += int'(stallM);
            chk("req_wait", 32'(bus_req), 32'd1);
            chk("bus_addr", bus_addr, exp_addr);
            chk("bus_we", 32'(bus_we), 32'(exp_we));
            if (exp_we) chk("bus_wdata", bus_wdata, wdata);
            @(posedge clk); #1;
            bus_ack = 1'b0; bus_rdata = $urandom;
        end
        @(negedge clk);
        chk("stall_cycles", 32'(st), 32'(exp_stall));
        chk("stall_done", 32'(stallM), 32'd0);
        chk("readdata_done", readdataM, exp_rd);
        chk("buserr_done", 32'(buserrM), 32'd0);
        chk("req_done", 32'(bus_req), 32'd0);
        @(posedge clk); #1;
        memreadM = 1'b0; memwriteM = 1'b0;
        @(negedge clk);
        chk("req_idle", 32'(bus_req), 32'd0);
        chk("stall_idle", 32'(stallM), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic        r_rd, r_wr, mis;
        logic [31:0] r_addr, r_wdata, r_rdata, e_rd;
        int          r_dly, n;

        rst = 1'b0;
        memreadM = 1'b0; memwriteM = 1'b0; aluoutM = '0; writedataM = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        t_rd = 1'b0; t_wr = 1'b0; t_addr = '0; t_wdata = '0;
        t_ack = 1'b0; t_rdata = '0;
        m_rd = '0;

        // Directed vectors, applied in order (readdataM carries over)
        vt[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,           1, 32'h1234_5678, 1'b0, 1'b0, 2, 32'h1234_5678, 1'b0};
        vt[1] = '{1'b0, 1'b1, 32'h0000_0024, 32'hCAFE_F00D,   5, 32'h5555_AAAA, 1'b0, 1'b0, 6, 32'h1234_5678, 1'b1};
        vt[2] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,           1, 32'h0,         1'b1, 1'b0, 0, 32'h1234_5678, 1'b0};
        vt[3] = '{1'b0, 1'b1, 32'h0000_0022, 32'h1111_2222,   1, 32'h0,         1'b0, 1'b1, 0, 32'h1234_5678, 1'b1};
        vt[4] = '{1'b1, 1'b1, 32'h0000_0008, 32'h0BAD_BEEF,   2, 32'hFFFF_FFFF, 1'b0, 1'b0, 3, 32'h1234_5678, 1'b1};
        vt[5] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,           3, 32'hDEAD_BEEF, 1'b0, 1'b0, 4, 32'hDEAD_BEEF, 1'b0};
        vt[6] = '{1'b1, 1'b1, 32'h0000_0041, 32'h3333_4444,   1, 32'h0,         1'b0, 1'b1, 0, 32'hDEAD_BEEF, 1'b1};

        // Reset state, with a stale ack present
        #23;
        @(negedge clk);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_we", 32'(bus_we), 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_readdata", readdataM, 32'd0);
        chk("rst_buserr", 32'(buserrM), 32'd0);
        chk("rst_stall", 32'(stallM), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h9999_9999;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("stale_ack_readdata", readdataM, 32'd0);
        chk("stale_ack_req", 32'(bus_req), 32'd0);

        for (int k = 0; k < 7; k++) begin
            do_txn(vt[k].rd, vt[k].wr, vt[k].addr, vt[k].wdata, vt[k].dly, vt[k].rdata,
                   vt[k].adel, vt[k].ades, vt[k].stall, vt[k].rdexp, vt[k].we);
        end
        m_rd = 32'hDEAD_BEEF;

        // Randomized transactions against the transaction-level model
        for (int k = 0; k < 40; k++) begin
            r_rd = 1'($urandom_range(0, 1));
            r_wr = 1'($urandom_range(0, 1));
            if (!r_rd && !r_wr) r_rd = 1'b1;
            r_addr = $urandom;
            if ($urandom_range(0, 3) != 0) r_addr[1:0] = 2'b00;
            r_wdata = $urandom;
            r_rdata = $urandom;
            r_dly   = int'($urandom_range(1, 6));
            mis     = (r_addr[1:0] != 2'b00);
            e_rd    = (!mis && !r_wr) ? r_rdata : m_rd;
            do_txn(r_rd, r_wr, r_addr, r_wdata, r_dly, r_rdata,
                   mis && !r_wr, mis && r_wr, mis ? 0 : 1 + r_dly, e_rd, r_wr);
            m_rd = e_rd;
        end

        // Timeout: prime readdataM with a good load, then let a load time out
        @(posedge clk); #1;
        t_rd = 1'b1; t_addr = 32'h0000_0100;
        @(posedge clk); #1;
        t_ack = 1'b1; t_rdata = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        t_ack = 1'b0;
        @(negedge clk);
        chk("t_prime_readdata", t_readdata, 32'hA5A5_A5A5);
        @(posedge clk); #1;
        t_rd = 1'b0;
        @(posedge clk); #1;
        t_rd = 1'b1; t_addr = 32'h0000_0200;
        @(posedge clk); #1;
        n = 0;
        @(negedge clk);
        while (t_req && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("t_req_cycles", 32'(n), 32'd4);
        chk("t_buserr_done", 32'(t_buserr), 32'd1);
        chk("t_readdata_done", t_readdata, 32'd0);
        chk("t_stall_done", 32'(t_stall), 32'd0);
        @(posedge clk); #1;
        t_rd = 1'b0;
        @(negedge clk);
        chk("t_buserr_idle", 32'(t_buserr), 32'd0);
        chk("t_req_idle", 32'(t_req), 32'd0);
        chk("t_stall_idle", 32'(t_stall), 32'd0);

        // Reset asserted mid-WAIT abandons the transaction
        @(posedge clk); #1;
        memreadM = 1'b1; aluoutM = 32'h0000_0030;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rw_req_before", 32'(bus_req), 32'd1);
        #2;
        rst = 1'b0; memreadM = 1'b0;
        #1;
        chk("rw_req_async", 32'(bus_req), 32'd0);
        chk("rw_stall", 32'(stallM), 32'd0);
        chk("rw_addr", bus_addr, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("rw_late_ack_readdata", readdataM, 32'd0);
        chk("rw_late_ack_req", 32'(bus_req), 32'd0);
        chk("rw_late_ack_stall", 32'(stallM), 32'd0);
        chk("rw_late_ack_buserr", 32'(buserrM), 32'd0);
        m_rd = '0;

        // Bridge still usable after the abandoned transaction
        do_txn(1'b1, 1'b0, 32'h0000_0044, 32'h0, 2, 32'h0F0F_1234, 1'b0, 1'b0, 3, 32'h0F0F_1234, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_bridge.md
Name: data_mem_bridge

Overview:
- Sits directly downstream of the pipelined CPU's memory stage. Consumes the M-stage request: memwrite/memread strobe, ALU-computed address and store data.
- Converts each request into a single-outstanding req/ack transaction on a variable-latency data bus.
- Returns load data plus a stall that holds the pipeline until the bus responds. Also flags misaligned accesses and bus timeouts.

Parameters:
- ADDR_W, 32, bus address width. The address is taken from the low ADDR_W bits of aluoutM.
- TIMEOUT, 255, maximum WAIT cycles without ack before the transaction is aborted. Must be ≥1 and fit in 8 bits.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- memwriteM  in  1  M-stage store request
- memreadM  in  1  M-stage load request
- aluoutM  in  32  M-stage byte address
- writedataM  in  32  M-stage store data
- readdataM  out  32  load data returned to the pipeline
- stallM  out  1  pipeline hold; the CPU freezes F/D/E/M while high
- adelM  out  1  misaligned load flag (combinational)
- adesM  out  1  misaligned store flag (combinational)
- buserrM  out  1  timeout flag, valid in DONE
- bus_req  out  1  request valid (registered)
- bus_we  out  1  1 = write (registered)
- bus_addr  out  ADDR_W  word address, bits [1:0] forced to 0 (registered)
- bus_wdata  out  32  store data (registered)
- bus_ack  in  1  one-cycle completion pulse from the memory
- bus_rdata  in  32  load data, valid when bus_ack=1

Behaviour:
- Reset, on rst=0, asynchronous:
  - state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0.
  - readdataM register=0, timeout counter=0, buserrM=0.
  - stallM follows the IDLE equation.
- Access type:
  - Word accesses only.
  - act = memreadM | memwriteM.
  - If both are high, the request is a write (write priority).
- Alignment, combinational, evaluated in IDLE only:
  - mis = act & (aluoutM[1:0] != 0).
  - adesM = mis & memwriteM.
  - adelM = mis & ~memwriteM.
  - A misaligned request issues no bus transaction and does not stall.
- FSM states:
  - IDLE:
    - stallM = act & ~mis, combinational.
    - On the clock edge with act & ~mis: latch bus_addr, bus_we, bus_wdata; set bus_req=1; clear counter; go to WAIT.
    - bus_ack is ignored in IDLE, including a stale ack after reset.
  - WAIT:
    - stallM=1. bus_req, bus_addr, bus_we and bus_wdata stay stable.
    - bus_ack is sampled at every edge, including the first edge after entry.
    - On ack: readdataM <= bus_rdata (loads only; writes leave readdataM unchanged), bus_req <= 0, buserrM <= 0, go to DONE.
    - Otherwise counter increments. When counter == TIMEOUT-1 with no ack: bus_req <= 0, readdataM <= 0, buserrM <= 1, go to DONE.
  - DONE:
    - stallM=0 for exactly one cycle; readdataM is valid for the W-stage capture.
    - Inputs are ignored, so the same instruction is not re-issued.
    - Next edge: go to IDLE, buserrM <= 0.
- Latency:
  - Minimum, ack on the first WAIT edge: 3 cycles. That is 1 IDLE-stall cycle + 1 WAIT + 1 DONE, so the pipeline is held 2 cycles.
  - General: stall cycles = 1 + (number of WAIT cycles).
- bus_ack arriving in DONE or IDLE is a protocol error and is ignored.
- bus_req drops in the same edge that samples ack. No back-to-back req without an intervening DONE/IDLE.
- Reset mid-transaction:
  - Bus outputs drop immediately.
  - The memory must tolerate an abandoned request.
  - The pipeline restarts from reset, so no data is returned.

Test Plan:
- Aligned load, memreadM=1, aluoutM=0x00000010, bus_ack on the 1st WAIT edge with bus_rdata=0x12345678:
  - bus_addr=0x10, bus_we=0.
  - stallM high 2 cycles.
  - readdataM=0x12345678 in the DONE cycle.
- Aligned store, memwriteM=1, aluoutM=0x00000024, writedataM=0xCAFEF00D, ack after 5 WAIT cycles:
  - bus_we=1, bus_wdata=0xCAFEF00D, held stable for 5 cycles.
  - stallM high 6 cycles.
  - readdataM unchanged.
- Misaligned load at aluoutM=0x00000013: adelM=1 the same cycle, stallM=0, bus_req never rises.
- Misaligned store at 0x00000022: adesM=1, adelM=0.
- Timeout with TIMEOUT=4 and no ack:
  - bus_req high 4 cycles then drops.
  - DONE with buserrM=1, readdataM=0.
  - IDLE next cycle.
- rst pulsed low during WAIT:
  - bus_req=0 asynchronously, state IDLE, stallM=0.
  - A bus_ack arriving afterwards causes no change.
- memreadM=memwriteM=1 at 0x00000008: a write transaction issues (bus_we=1).
